// File: rtl/usb_ep_pkg.sv
// Shared types and helpers for the USB OUT endpoint slot controller.
package usb_ep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DROP = 2'd2
   } ep_state_e;

   localparam int STAT_W = 16;

   // 32-bit word address of the first byte of a slot of 2^slot_aw bytes.
   function automatic int unsigned slot_base(input int unsigned slot, input int unsigned slot_aw);
      return slot << (slot_aw - 2);
   endfunction

endpackage

// File: rtl/usb_ep_slot_fifo.sv
// Slot bookkeeping: write/read slot pointers, fill count and per-slot packet lengths.
module usb_ep_slot_fifo
   import usb_ep_pkg::*;
#(
   parameter int NSLOT   = 2,
   parameter int SLOT_AW = 6,
   parameter int PW      = $clog2(NSLOT)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic [SLOT_AW:0]   push_len,
   input  logic               pop,
   output logic [PW-1:0]      wr_slot,
   output logic [PW-1:0]      rd_slot,
   output logic [SLOT_AW:0]   rd_len,
   output logic               full,
   output logic               empty
);

   localparam int CW = $clog2(NSLOT + 1);

   logic [CW-1:0]    count;
   logic [SLOT_AW:0] len [NSLOT];
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CW'(NSLOT));
   assign empty   = (count == '0);
   assign pop_ok  = pop & ~empty;
   // A release in the same cycle frees room for the commit.
   assign push_ok = push & (~full | pop_ok);
   assign rd_len  = len[rd_slot];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_slot <= '0;
         rd_slot <= '0;
         count   <= '0;
         for (int i = 0; i < NSLOT; i++) len[i] <= '0;
      end else begin
         if (push_ok) begin
            len[wr_slot] <= push_len;
            wr_slot      <= wr_slot + PW'(1);
         end
         if (pop_ok) rd_slot <= rd_slot + PW'(1);
         if (push_ok && !pop_ok)      count <= count + CW'(1);
         else if (pop_ok && !push_ok) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/usb_ep_slot_ctrl.sv
// OUT endpoint slot controller: packet FSM, RAM write address generation, CPU slot view.
// Optional statistics counters are enabled by defining USB_EP_SLOT_STATS_EN.
//
// state | meaning
// IDLE  | waiting for p_start
// FILL  | receiving bytes into slot wr_slot
// DROP  | NAKed packet, bytes ignored until commit/abort
module usb_ep_slot_ctrl
   import usb_ep_pkg::*;
#(
   parameter int NSLOT   = 2,
   parameter int SLOT_AW = 6,
   parameter int AWIDTH  = 11
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                p_start,
   input  logic                p_wr,
   input  logic                p_commit,
   input  logic                p_abort,
   output logic                p_ready,
   output logic                p_ovf,
   output logic [AWIDTH-1:0]   buf_wr_addr,
   output logic                buf_wr_en,
   output logic                c_valid,
   output logic [AWIDTH-3:0]   c_base,
   output logic [SLOT_AW:0]    c_len,
   input  logic                c_release
`ifdef USB_EP_SLOT_STATS_EN
   ,
   input  logic                stat_clr,
   output logic [STAT_W-1:0]   stat_nak,
   output logic [STAT_W-1:0]   stat_ovf
`endif
);

   localparam int PW = $clog2(NSLOT);

   ep_state_e        state, state_nxt;
   logic [SLOT_AW:0] bptr, bptr_nxt;
   logic             ovf_nxt;
   logic             push;
   logic [PW-1:0]    wr_slot, rd_slot;
   logic             full, empty;

   usb_ep_slot_fifo #(
      .NSLOT   (NSLOT),
      .SLOT_AW (SLOT_AW),
      .PW      (PW)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_len (bptr),
      .pop      (c_release),
      .wr_slot  (wr_slot),
      .rd_slot  (rd_slot),
      .rd_len   (c_len),
      .full     (full),
      .empty    (empty)
   );

   assign p_ready     = ~full;
   assign c_valid     = ~empty;
   assign c_base      = (AWIDTH-2)'(slot_base(32'(rd_slot), SLOT_AW));
   assign buf_wr_addr = AWIDTH'({wr_slot, bptr[SLOT_AW-1:0]});
   assign buf_wr_en   = p_wr & (state == ST_FILL) & ~bptr[SLOT_AW];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         bptr  <= '0;
         p_ovf <= 1'b0;
      end else begin
         state <= state_nxt;
         bptr  <= bptr_nxt;
         p_ovf <= ovf_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      bptr_nxt  = bptr;
      ovf_nxt   = p_ovf;
      push      = 1'b0;
      // A start from any state begins a fresh packet; the NAK decision uses the registered count.
      if (p_start) begin
         if (p_ready) begin
            state_nxt = ST_FILL;
            bptr_nxt  = '0;
            ovf_nxt   = 1'b0;
         end else begin
            state_nxt = ST_DROP;
         end
      end else begin
         case (state)
            ST_FILL: begin
               if (p_abort) begin
                  state_nxt = ST_IDLE;
               end else if (p_commit) begin
                  push      = ~p_ovf;
                  state_nxt = ST_IDLE;
               end else if (p_wr) begin
                  if (!bptr[SLOT_AW]) bptr_nxt = bptr + (SLOT_AW+1)'(1);
                  else                ovf_nxt  = 1'b1;
               end
            end
            ST_DROP: begin
               if (p_commit || p_abort) state_nxt = ST_IDLE;
            end
            default: ;
         endcase
      end
   end

`ifdef USB_EP_SLOT_STATS_EN
   logic nak_evt, ovf_evt;

   assign nak_evt = p_start & ~p_ready;
   assign ovf_evt = ~p_start & (state == ST_FILL) & ~p_abort & p_commit & p_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_nak <= '0;
         stat_ovf <= '0;
      end else if (stat_clr) begin
         stat_nak <= '0;
         stat_ovf <= '0;
      end else begin
         if (nak_evt && stat_nak != '1) stat_nak <= stat_nak + STAT_W'(1);
         if (ovf_evt && stat_ovf != '1) stat_ovf <= stat_ovf + STAT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_usb_ep_slot_ctrl.sv
// Self-checking bench for usb_ep_slot_ctrl: directed scenarios plus random traffic against a queue model.
module tb_usb_ep_slot_ctrl;

   localparam int NSLOT   = 2;
   localparam int SLOT_AW = 6;
   localparam int AWIDTH  = 11;
   localparam int SLOT_B  = 1 << SLOT_AW;
   localparam int M_IDLE  = 0;
   localparam int M_FILL  = 1;
   localparam int M_DROP  = 2;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                p_start = 1'b0;
   logic                p_wr = 1'b0;
   logic                p_commit = 1'b0;
   logic                p_abort = 1'b0;
   logic                c_release = 1'b0;
   logic                p_ready, p_ovf, buf_wr_en, c_valid;
   logic [AWIDTH-1:0]   buf_wr_addr;
   logic [AWIDTH-3:0]   c_base;
   logic [SLOT_AW:0]    c_len;
   logic                s_clr = 1'b0;
`ifdef USB_EP_SLOT_STATS_EN
   logic [15:0]         stat_nak, stat_ovf;
`endif

   always #5 clk = ~clk;

   usb_ep_slot_ctrl #(
      .NSLOT   (NSLOT),
      .SLOT_AW (SLOT_AW),
      .AWIDTH  (AWIDTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .p_start     (p_start),
      .p_wr        (p_wr),
      .p_commit    (p_commit),
      .p_abort     (p_abort),
      .p_ready     (p_ready),
      .p_ovf       (p_ovf),
      .buf_wr_addr (buf_wr_addr),
      .buf_wr_en   (buf_wr_en),
      .c_valid     (c_valid),
      .c_base      (c_base),
      .c_len       (c_len),
      .c_release   (c_release)
`ifdef USB_EP_SLOT_STATS_EN
      ,
      .stat_clr    (s_clr),
      .stat_nak    (stat_nak),
      .stat_ovf    (stat_ovf)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: queue of committed packet lengths plus packet-in-progress bookkeeping.
   int q[$];
   int m_wr, m_rd, m_mode, m_cur, m_nak, m_ovfc;
   bit m_ovf;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_wr = 0; m_rd = 0; m_mode = M_IDLE; m_cur = 0; m_ovf = 0;
      m_nak = 0; m_ovfc = 0;
   endtask

   task automatic check_outputs();
      check("p_ready", p_ready, q.size() < NSLOT);
      check("c_valid", c_valid, q.size() > 0);
      check("c_base", c_base, m_rd * SLOT_B / 4);
      if (q.size() > 0) check("c_len", c_len, q[0]);
      check("p_ovf", p_ovf, m_ovf);
      check("buf_wr_addr", buf_wr_addr, m_wr * SLOT_B + m_cur % SLOT_B);
      check("buf_wr_en", buf_wr_en, p_wr && m_mode == M_FILL && m_cur < SLOT_B);
`ifdef USB_EP_SLOT_STATS_EN
      check("stat_nak", stat_nak, m_nak);
      check("stat_ovf", stat_ovf, m_ovfc);
`endif
   endtask

   task automatic model_update(input bit s, input bit w, input bit cm, input bit ab, input bit rl, input bit clr);
      bit was_full, do_pop, do_push, ovf_commit;
      int plen;
      was_full = (q.size() == NSLOT);
      do_pop = rl && q.size() > 0;
      do_push = 0; ovf_commit = 0; plen = m_cur;
      if (s) begin
         if (!was_full) begin m_mode = M_FILL; m_cur = 0; m_ovf = 0; end
         else m_mode = M_DROP;
      end else if (m_mode == M_FILL) begin
         if (ab) m_mode = M_IDLE;
         else if (cm) begin
            if (!m_ovf) do_push = 1; else ovf_commit = 1;
            m_mode = M_IDLE;
         end else if (w) begin
            if (m_cur < SLOT_B) m_cur++; else m_ovf = 1;
         end
      end else if (m_mode == M_DROP && (cm || ab)) m_mode = M_IDLE;
      if (do_pop) begin void'(q.pop_front()); m_rd = (m_rd + 1) % NSLOT; end
      if (do_push) begin q.push_back(plen); m_wr = (m_wr + 1) % NSLOT; end
      if (clr) begin m_nak = 0; m_ovfc = 0; end
      else begin
         if (s && was_full && m_nak < 65535) m_nak++;
         if (ovf_commit && m_ovfc < 65535) m_ovfc++;
      end
   endtask

   // Called just after a rising edge; inputs held for one cycle, outputs checked at the falling edge.
   task automatic step(input bit s, input bit w, input bit cm, input bit ab, input bit rl);
      p_start = s; p_wr = w; p_commit = cm; p_abort = ab; c_release = rl;
      @(negedge clk);
      check_outputs();
      model_update(s, w, cm, ab, rl, s_clr);
      @(posedge clk);
      #1;
      p_start = 0; p_wr = 0; p_commit = 0; p_abort = 0; c_release = 0; s_clr = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      p_start = 0; p_wr = 0; p_commit = 0; p_abort = 0; c_release = 0; s_clr = 0;
      model_reset();
      #1;
      check("rst c_valid", c_valid, 0);
      check("rst p_ready", p_ready, 1);
      check("rst p_ovf", p_ovf, 0);
      check("rst buf_wr_addr", buf_wr_addr, 0);
      check("rst buf_wr_en", buf_wr_en, 0);
      check("rst c_base", c_base, 0);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic packet(input int nbytes);
      step(1, 0, 0, 0, 0);
      repeat (nbytes) step(0, 1, 0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      do_reset();

      // 10-byte packet into slot 0
      packet(10);
      step(0, 0, 1, 0, 0);
      check("pkt10 c_valid", c_valid, 1);
      check("pkt10 c_base", c_base, 0);
      check("pkt10 c_len", c_len, 10);
      step(0, 0, 0, 0, 1);

      // two packets fill the buffer, third is NAKed
      do_reset();
      packet(64); step(0, 0, 1, 0, 0);
      packet(5);  step(0, 0, 1, 0, 0);
      check("full p_ready", p_ready, 0);
      packet(3);  step(0, 0, 1, 0, 0);
      check("drop c_valid", c_valid, 1);
      check("drop c_len", c_len, 64);
      step(0, 0, 0, 0, 1);
      check("rel c_base", c_base, 16);
      check("rel c_len", c_len, 5);

      // overflow: 65th byte is not written, commit discards the packet
      do_reset();
      packet(65);
      check("ovf p_ovf", p_ovf, 1);
      step(0, 0, 1, 0, 0);
      check("ovf c_valid", c_valid, 0);
`ifdef USB_EP_SLOT_STATS_EN
      check("ovf stat_ovf", stat_ovf, 1);
`endif

      // abort wins over commit
      do_reset();
      packet(3);
      step(0, 0, 1, 1, 0);
      check("abort c_valid", c_valid, 0);

      // commit and release together, pointers wrapping over 20 packets
      do_reset();
      for (int i = 0; i < 20; i++) begin
         packet(i % 5);
         step(0, 0, 1, 0, 1);
         check("wrap c_valid", c_valid, 1);
         check("wrap c_len", c_len, i % 5);
         check("wrap c_base", c_base, (i % 2) * 16);
      end

      // zero-length packet, then reset in the middle of a fill
      do_reset();
      packet(0);
      step(0, 0, 1, 0, 0);
      check("zero c_valid", c_valid, 1);
      check("zero c_len", c_len, 0);
      packet(3);
      do_reset();
      check("midrst c_valid", c_valid, 0);
      check("midrst p_ready", p_ready, 1);

      // random traffic
      for (int i = 0; i < 800; i++) begin
         s_clr = ($urandom_range(99) < 2);
         step($urandom_range(99) < 4, $urandom_range(99) < 70, $urandom_range(99) < 5,
              $urandom_range(99) < 2, $urandom_range(99) < 12);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
